output_buffer: RTL

- Receiving end of the systolic array's `of_data` output.
- The array emits each output row skewed: column c of row r appears one cycle after column c-1.
- The block deskews each row into an aligned row and stores it in a row FIFO.
- It drains rows to the downstream writer over a valid/ready handshake and raises a done pulse when the expected row count has been drained.

---
 rtl/output_buffer_pkg.sv | 13 +
 rtl/obuf_fifo.sv | 62 ++++++
 rtl/output_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/output_buffer_pkg.sv
// Shared configuration for the systolic-array output buffer: array geometry,
// FIFO sizing and the aligned output row type.
package output_buffer_pkg;

  localparam int sys_cols       = 4;
  localparam int P_BITWIDTH     = 16;
  localparam int A_rows         = 8;
  localparam int obuf_depth     = 4;
  localparam int obuf_cnt_width = $clog2(obuf_depth + 1);

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] out_row_t;

endpackage

// File: rtl/obuf_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is always presented on dout,
// a push that finds the FIFO full is still accepted when a pop happens in the same cycle.
module obuf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO reads as zero so the output row is clean after reset/flush.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/output_buffer.sv
// Deskews the systolic array's staggered output rows, queues aligned rows and drains
// them over valid/ready. Optional build macro OBUF_RELU_EN clamps negative words to 0.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int SYS_COLS   = sys_cols,
  parameter int P_BITWIDTH = output_buffer_pkg::P_BITWIDTH,
  parameter int DEPTH      = obuf_depth,
  parameter int ROWS       = A_rows
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             i_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0]   of_data,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [SYS_COLS*P_BITWIDTH-1:0]   o_data,
  output logic                             o_done,
  output logic                             overflow,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);

  localparam int W  = SYS_COLS * P_BITWIDTH;
  localparam int DW = $clog2(ROWS + 1);

  logic [SYS_COLS-2:0] vld_pipe_reg;
  logic                wr_valid;
  logic [W-1:0]        aligned_row;
  logic [W-1:0]        fifo_din;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;
  logic                last_row;
  logic                overflow_reg;
  logic [DW-1:0]       drain_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg <= '0;
    end else if (clr) begin
      vld_pipe_reg <= '0;
    end else begin
      vld_pipe_reg[0] <= i_valid;
      for (int k = 1; k < SYS_COLS - 1; k++) vld_pipe_reg[k] <= vld_pipe_reg[k-1];
    end
  end

  assign wr_valid = vld_pipe_reg[SYS_COLS-2];

  // Column c arrives c cycles late, so it is delayed by the remaining SYS_COLS-1-c cycles.
  for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_col
    localparam int NST = SYS_COLS - 1 - gi;
    if (NST == 0) begin : g_direct
      assign aligned_row[gi*P_BITWIDTH +: P_BITWIDTH] = of_data[gi*P_BITWIDTH +: P_BITWIDTH];
    end else begin : g_dly
      logic [P_BITWIDTH-1:0] dly_reg [NST];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < NST; k++) dly_reg[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < NST; k++) dly_reg[k] <= '0;
        end else begin
          dly_reg[0] <= of_data[gi*P_BITWIDTH +: P_BITWIDTH];
          for (int k = 1; k < NST; k++) dly_reg[k] <= dly_reg[k-1];
        end
      end
      assign aligned_row[gi*P_BITWIDTH +: P_BITWIDTH] = dly_reg[NST-1];
    end
`ifdef OBUF_RELU_EN
    assign fifo_din[gi*P_BITWIDTH +: P_BITWIDTH] =
      aligned_row[gi*P_BITWIDTH + P_BITWIDTH - 1] ? '0 : aligned_row[gi*P_BITWIDTH +: P_BITWIDTH];
`endif
  end

`ifndef OBUF_RELU_EN
  assign fifo_din = aligned_row;
`endif

  obuf_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (wr_valid),
    .pop   (o_ready),
    .din   (fifo_din),
    .dout  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  assign o_valid  = !fifo_empty;
  assign pop      = o_valid && o_ready;
  assign drop     = wr_valid && fifo_full && !pop;
  assign last_row = (drain_cnt_reg == DW'(ROWS - 1));
  assign o_done   = pop && last_row && !clr;
  assign overflow = overflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      drain_cnt_reg <= '0;
    end else if (clr) begin
      overflow_reg  <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      if (drop) overflow_reg <= 1'b1;
      if (pop)  drain_cnt_reg <= last_row ? '0 : drain_cnt_reg + 1'b1;
    end
  end

endmodule
